// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm clock trigger FSM with snooze, ring timeout and missed-alarm flag
module alarm_trigger #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic       arm,
    input  logic       set_load,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       alarm_en,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic       missed
);
    localparam logic [6:0] SMIN = 7'(SNOOZE_MIN);
    localparam logic [7:0] TLAST = 8'(RING_TIMEOUT - 1);
    localparam logic [1:0] MAXS = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t     state, nxt;
    logic       match, smatch, match_d, smatch_d;
    logic       load_ok, timeout, go_idle, do_snooze, set_missed;
    logic [7:0] sec_cnt;
    logic [4:0] tgt_hr;
    logic [5:0] tgt_min;
    logic [6:0] sum_min;
    logic       min_wrap;
    logic [4:0] hr_inc;

    assign match    = cur_hr == alarm_hr && cur_min == alarm_min;
    assign smatch   = cur_hr == tgt_hr && cur_min == tgt_min;
    assign load_ok  = set_load && set_hr <= 5'd23 && set_min <= 6'd59;
    assign timeout  = sec_tick && sec_cnt == TLAST;
    assign sum_min  = {1'b0, cur_min} + SMIN;
    assign min_wrap = sum_min >= 7'd60;
    assign hr_inc   = cur_hr == 5'd23 ? 5'd0 : cur_hr + 5'd1;

    // next-state decode; arm low beats dismiss beats snooze beats timeout beats match
    always_comb begin
        nxt        = state;
        go_idle    = 1'b0;
        do_snooze  = 1'b0;
        set_missed = 1'b0;
        if (!arm) begin
            nxt     = IDLE;
            go_idle = 1'b1;
        end else begin
            case (state)
                IDLE: nxt = match && !match_d ? RINGING : IDLE;
                RINGING: begin
                    if (dismiss) begin
                        nxt     = IDLE;
                        go_idle = 1'b1;
                    end else if (snooze && snooze_cnt < MAXS) begin
                        nxt       = SNOOZE;
                        do_snooze = 1'b1;
                    end else if (timeout) begin
                        nxt        = IDLE;
                        go_idle    = 1'b1;
                        set_missed = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        nxt     = IDLE;
                        go_idle = 1'b1;
                    end else if (smatch && !smatch_d) begin
                        nxt = RINGING;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // state register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            alarm_en   <= 1'b0;
            snoozing   <= 1'b0;
            snooze_cnt <= 2'd0;
            missed     <= 1'b0;
        end else begin
            state      <= nxt;
            alarm_en   <= nxt == RINGING;
            snoozing   <= nxt == SNOOZE;
            snooze_cnt <= go_idle ? 2'd0 : do_snooze ? snooze_cnt + 2'd1 : snooze_cnt;
            missed     <= set_missed ? 1'b1 : (set_load || dismiss) ? 1'b0 : missed;
        end
    end

    // stored alarm time; out-of-range loads are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_hr  <= 5'd0;
            alarm_min <= 6'd0;
        end else if (load_ok) begin
            alarm_hr  <= set_hr;
            alarm_min <= set_min;
        end
    end

    // previous match values; reset high so 00:00 at release is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            match_d  <= 1'b1;
            smatch_d <= 1'b1;
        end else begin
            match_d  <= match;
            smatch_d <= smatch;
        end
    end

    // snooze target = current time + SNOOZE_MIN with minute and midnight wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_hr  <= 5'd0;
            tgt_min <= 6'd0;
        end else if (do_snooze) begin
            tgt_hr  <= min_wrap ? hr_inc : cur_hr;
            tgt_min <= min_wrap ? 6'(sum_min - 7'd60) : sum_min[5:0];
        end
    end

    // ringing seconds counter, cleared on every entry to RINGING
    always_ff @(posedge clk) begin
        if (reset) sec_cnt <= 8'd0;
        else if (nxt == RINGING && state != RINGING) sec_cnt <= 8'd0;
        else if (state == RINGING && sec_tick) sec_cnt <= sec_cnt + 8'd1;
    end
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: vector table, directed corner sequences and randomized model check
module tb_alarm_trigger;
    localparam int SNZ = 5;
    localparam int TMO = 60;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1, sec_tick = 1'b0, arm = 1'b0, set_load = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic [4:0] cur_hr = 5'd0, set_hr = 5'd0;
    logic [5:0] cur_min = 6'd0, set_min = 6'd0;
    logic       alarm_en, snoozing, missed;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [1:0] snooze_cnt;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int rst, arm, ld, shr, smin, snz, dis, tick, chr, cmin;
        int en, sn, cnt, mis, ahr, amin;
    } vec_t;

    vec_t tbl[$];

    alarm_trigger #(.SNOOZE_MIN(SNZ), .RING_TIMEOUT(TMO), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .cur_hr(cur_hr), .cur_min(cur_min),
        .arm(arm), .set_load(set_load), .set_hr(set_hr), .set_min(set_min),
        .snooze(snooze), .dismiss(dismiss), .alarm_en(alarm_en), .alarm_hr(alarm_hr),
        .alarm_min(alarm_min), .snoozing(snoozing), .snooze_cnt(snooze_cnt), .missed(missed)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(int rst, int ar, int ld, int shr, int smin, int snz, int dis, int tick,
                               int chr, int cmin, int en, int sn, int cnt, int mis, int ahr, int amin);
        vec_t r;
        r.rst = rst; r.arm = ar; r.ld = ld; r.shr = shr; r.smin = smin; r.snz = snz; r.dis = dis;
        r.tick = tick; r.chr = chr; r.cmin = cmin; r.en = en; r.sn = sn; r.cnt = cnt; r.mis = mis;
        r.ahr = ahr; r.amin = amin;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        reset = 1'(x.rst); arm = 1'(x.arm); set_load = 1'(x.ld); set_hr = 5'(x.shr); set_min = 6'(x.smin);
        snooze = 1'(x.snz); dismiss = 1'(x.dis); sec_tick = 1'(x.tick); cur_hr = 5'(x.chr); cur_min = 6'(x.cmin);
    endtask

    task automatic check_outs(string tag, int en, int sn, int cnt, int mis, int ahr, int amin);
        chk({tag, ".alarm_en"}, int'(alarm_en), en);
        chk({tag, ".snoozing"}, int'(snoozing), sn);
        chk({tag, ".snooze_cnt"}, int'(snooze_cnt), cnt);
        chk({tag, ".missed"}, int'(missed), mis);
        chk({tag, ".alarm_hr"}, int'(alarm_hr), ahr);
        chk({tag, ".alarm_min"}, int'(alarm_min), amin);
    endtask

    task automatic apply(string tag, vec_t x);
        drive(x);
        @(posedge clk);
        #1;
        check_outs(tag, x.en, x.sn, x.cnt, x.mis, x.ahr, x.amin);
    endtask

    // behavioural reference: time kept as minutes of day
    int m_st, m_alarm, m_tgt, m_pm, m_psm, m_secs, m_cnt, m_mis;

    task automatic model_step(vec_t x);
        int now, ns, leave, snz_ok, tmo, mt, smt;
        if (x.rst != 0) begin
            m_st = 0; m_alarm = 0; m_tgt = 0; m_pm = 1; m_psm = 1; m_secs = 0; m_cnt = 0; m_mis = 0;
            return;
        end
        now = x.chr * 60 + x.cmin;
        mt = int'(now == m_alarm);
        smt = int'(now == m_tgt);
        ns = m_st; leave = 0; snz_ok = 0; tmo = 0;
        if (x.arm == 0) begin
            ns = 0; leave = 1;
        end else if (m_st == 0) begin
            if (mt != 0 && m_pm == 0) ns = 1;
        end else if (m_st == 1) begin
            if (x.dis != 0) begin ns = 0; leave = 1; end
            else if (x.snz != 0 && m_cnt < MAXS) begin ns = 2; snz_ok = 1; end
            else if (x.tick != 0 && m_secs + 1 == TMO) begin ns = 0; leave = 1; tmo = 1; end
        end else begin
            if (x.dis != 0) begin ns = 0; leave = 1; end
            else if (smt != 0 && m_psm == 0) ns = 1;
        end
        if (ns == 1 && m_st != 1) m_secs = 0;
        else if (m_st == 1 && x.tick != 0) m_secs++;
        m_cnt = leave != 0 ? 0 : m_cnt + snz_ok;
        m_mis = tmo != 0 ? 1 : (x.ld != 0 || x.dis != 0) ? 0 : m_mis;
        if (x.ld != 0 && x.shr < 24 && x.smin < 60) m_alarm = x.shr * 60 + x.smin;
        if (snz_ok != 0) m_tgt = (now + SNZ) % 1440;
        m_pm = mt;
        m_psm = smt;
        m_st = ns;
    endtask

    initial begin
        int t, idx;
        vec_t x;
        int times[12];
        // rst arm ld shr smin snz dis tick chr cmin | en sn cnt mis ahr amin
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 7, 30, 0, 0, 0, 7, 29, 0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 7, 29,  0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  1, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 7, 30,  1, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 7, 30,  0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 7, 30,  0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 1, 24, 10, 0, 0, 0, 7, 31, 0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 1, 7, 60, 0, 0, 0, 7, 31, 0, 0, 0, 0, 7, 30));
        tbl.push_back(v(0, 1, 1, 23, 58, 0, 0, 0, 23, 57, 0, 0, 0, 0, 23, 58));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 23, 58, 1, 0, 0, 0, 23, 58));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 23, 58, 0, 1, 1, 0, 23, 58));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 23, 59, 0, 1, 1, 0, 23, 58));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 3,   1, 0, 1, 0, 23, 58));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 3,   0, 0, 0, 0, 23, 58));
        tbl.push_back(v(0, 1, 1, 0, 5, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 5));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 5,   1, 0, 0, 0, 0, 5));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0, 5));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0, 5));
        tbl.push_back(v(0, 1, 1, 0, 7, 0, 0, 0, 0, 6,   0, 0, 0, 0, 0, 7));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 7,   1, 0, 0, 0, 0, 7));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, 0, 0, 7,   0, 1, 1, 0, 0, 7));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 8,   0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 59,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // ring timeout after TMO seconds, then set_load clears missed
        apply("to_load", v(0, 1, 1, 2, 0, 0, 0, 0, 1, 59, 0, 0, 0, 0, 2, 0));
        apply("to_ring", v(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 2, 0));
        for (int i = 1; i < TMO; i++) begin
            drive(v(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            drive(v(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        check_outs("to_before", 1, 0, 0, 0, 2, 0);
        apply("to_last", v(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0));
        apply("to_hold", v(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 2, 0));
        apply("to_clr", v(0, 1, 1, 3, 0, 0, 0, 0, 2, 59, 0, 0, 0, 0, 3, 0));

        // snooze limit: three snoozes accepted, the fourth ignored
        apply("sn_ring", v(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 3, 0));
        for (int k = 1; k <= MAXS; k++) begin
            t = 180 + SNZ * (k - 1);
            apply($sformatf("sn%0d_go", k), v(0, 1, 0, 0, 0, 1, 0, 0, t / 60, t % 60, 0, 1, k, 0, 3, 0));
            t += SNZ;
            apply($sformatf("sn%0d_wait", k), v(0, 1, 0, 0, 0, 0, 0, 0, (t - 1) / 60, (t - 1) % 60, 0, 1, k, 0, 3, 0));
            apply($sformatf("sn%0d_wake", k), v(0, 1, 0, 0, 0, 0, 0, 0, t / 60, t % 60, 1, 0, k, 0, 3, 0));
        end
        apply("sn_extra", v(0, 1, 0, 0, 0, 1, 0, 0, 3, 15, 1, 0, 3, 0, 3, 0));
        apply("sn_stay", v(0, 1, 0, 0, 0, 0, 0, 0, 3, 15, 1, 0, 3, 0, 3, 0));
        apply("sn_dis", v(0, 1, 0, 0, 0, 0, 1, 0, 3, 15, 0, 0, 0, 0, 3, 0));

        // randomized run around midnight against the reference model
        for (int i = 0; i < 12; i++) times[i] = (1435 + i) % 1440;
        idx = 0;
        x = v(1, 1, 0, 0, 0, 0, 0, 0, 23, 55, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) begin
                x.rst = int'($urandom % 400 == 0);
                x.arm = int'($urandom % 40 != 0);
                x.ld = int'($urandom % 30 == 0);
                t = times[$urandom % 12];
                x.shr = $urandom % 6 == 0 ? int'($urandom_range(24, 31)) : t / 60;
                x.smin = $urandom % 8 == 0 ? int'($urandom_range(60, 63)) : t % 60;
                x.snz = int'($urandom % 8 == 0);
                x.dis = int'($urandom % 50 == 0);
                x.tick = int'($urandom % 2 == 0);
                if ($urandom % 3 == 0) idx = int'($urandom % 12);
                x.chr = times[idx] / 60;
                x.cmin = times[idx] % 60;
            end
            drive(x);
            model_step(x);
            @(posedge clk);
            #1;
            check_outs($sformatf("rnd%0d", c), int'(m_st == 1), int'(m_st == 2), m_cnt, m_mis,
                       m_alarm / 60, m_alarm % 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
